// File: rtl/step_seq_decoder.sv
// Quadrature-style phase decoder: 2-flop sync, stability filter, step/err pulses, wrapping position.
// Latency: STABLE_CYC+2 clocks from phase change to registered pulse; no backpressure, pulses are fire-and-forget.
// Optional STEP_SEQ_DEC_ERR_CNT_EN adds a saturating 8-bit o_err_cnt cleared by i_pos_clr.
module step_seq_decoder #(
    parameter int STABLE_CYC = 1000,
    parameter int POS_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_phase,
    input  logic             i_pos_clr,
    output logic             o_step_fwd,
    output logic             o_step_rev,
    output logic             o_err,
    output logic             o_dir,
    output logic             o_locked,
    output logic [POS_W-1:0] o_pos
`ifdef STEP_SEQ_DEC_ERR_CNT_EN
    ,
    output logic [7:0]       o_err_cnt
`endif
);

    localparam int CNT_W = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYC - 2);

    // Encoding equals the phase value, so forward is -1 and reverse is +1 mod 4.
    typedef enum logic [1:0] {
        S0 = 2'b11,
        S1 = 2'b10,
        S2 = 2'b01,
        S3 = 2'b00
    } state_t;

    logic [1:0]       r_sync1, r_sync2, r_cand;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_cur;
    logic             r_locked, r_dir;
    logic [POS_W-1:0] r_pos;
    logic             r_step_fwd, r_step_rev, r_err;

    logic [1:0]       w_cand_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    state_t           w_cur_nxt;
    logic             w_locked_nxt, w_dir_nxt;
    logic [POS_W-1:0] w_pos_nxt;
    logic             w_fwd_nxt, w_rev_nxt, w_err_nxt;
    logic             w_accept;
    logic [1:0]       w_fwd_succ, w_rev_succ;

    // Acceptance coincides with cnt reaching its saturation value, so it fires once per run.
    assign w_accept   = (r_sync2 == r_cand) && (r_cnt == CNT_ACC);
    assign w_fwd_succ = r_cur - 2'd1;
    assign w_rev_succ = r_cur + 2'd1;

    always_comb begin
        w_cand_nxt   = r_cand;
        w_cnt_nxt    = r_cnt;
        w_cur_nxt    = r_cur;
        w_locked_nxt = r_locked;
        w_dir_nxt    = r_dir;
        w_pos_nxt    = r_pos;
        w_fwd_nxt    = 1'b0;
        w_rev_nxt    = 1'b0;
        w_err_nxt    = 1'b0;

        if (r_sync2 != r_cand) begin
            w_cand_nxt = r_sync2;
            w_cnt_nxt  = '0;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        if (w_accept) begin
            if (!r_locked) begin
                w_cur_nxt    = state_t'(r_sync2);
                w_locked_nxt = 1'b1;
            end else if (r_sync2 == w_fwd_succ) begin
                w_cur_nxt = state_t'(r_sync2);
                w_fwd_nxt = 1'b1;
                w_dir_nxt = 1'b1;
                w_pos_nxt = r_pos + POS_W'(1);
            end else if (r_sync2 == w_rev_succ) begin
                w_cur_nxt = state_t'(r_sync2);
                w_rev_nxt = 1'b1;
                w_dir_nxt = 1'b0;
                w_pos_nxt = r_pos - POS_W'(1);
            end else if (r_sync2 != r_cur) begin
                w_cur_nxt = state_t'(r_sync2);
                w_err_nxt = 1'b1;
            end
        end

        if (i_pos_clr) begin
            w_pos_nxt = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync1    <= 2'b11;
            r_sync2    <= 2'b11;
            r_cand     <= 2'b11;
            r_cnt      <= '0;
            r_cur      <= S0;
            r_locked   <= 1'b0;
            r_dir      <= 1'b0;
            r_pos      <= '0;
            r_step_fwd <= 1'b0;
            r_step_rev <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_sync1    <= i_phase;
            r_sync2    <= r_sync1;
            r_cand     <= w_cand_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur      <= w_cur_nxt;
            r_locked   <= w_locked_nxt;
            r_dir      <= w_dir_nxt;
            r_pos      <= w_pos_nxt;
            r_step_fwd <= w_fwd_nxt;
            r_step_rev <= w_rev_nxt;
            r_err      <= w_err_nxt;
        end
    end

`ifdef STEP_SEQ_DEC_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_err_cnt <= 8'd0;
        end else if (i_pos_clr) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

    assign o_step_fwd = r_step_fwd;
    assign o_step_rev = r_step_rev;
    assign o_err      = r_err;
    assign o_dir      = r_dir;
    assign o_locked   = r_locked;
    assign o_pos      = r_pos;

endmodule

// File: tb/tb_step_seq_decoder.sv
// Directed bench for step_seq_decoder with STABLE_CYC=4, POS_W=8; edge k = k-th rising edge after a phase change.
module tb_step_seq_decoder;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [1:0] i_phase;
    logic       i_pos_clr;
    logic       o_step_fwd, o_step_rev, o_err, o_dir, o_locked;
    logic [7:0] o_pos;
`ifdef STEP_SEQ_DEC_ERR_CNT_EN
    logic [7:0] o_err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    step_seq_decoder #(.STABLE_CYC(4), .POS_W(8)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_phase    (i_phase),
        .i_pos_clr  (i_pos_clr),
        .o_step_fwd (o_step_fwd),
        .o_step_rev (o_step_rev),
        .o_err      (o_err),
        .o_dir      (o_dir),
        .o_locked   (o_locked),
        .o_pos      (o_pos)
`ifdef STEP_SEQ_DEC_ERR_CNT_EN
        ,
        .o_err_cnt  (o_err_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Apply a phase at a negedge, check quiet through edge 5, the pulse at edge 6, quiet at edge 7; hold 10 cycles.
    task automatic step_chk(input logic [1:0] ph, input logic [2:0] exp_pulse,
                            input logic [7:0] exp_pos, input logic exp_dir, input string tag);
        i_phase = ph;
        cyc(5);
        chk({tag, "_pre"}, 32'({o_step_fwd, o_step_rev, o_err}), 32'(3'b000));
        cyc(1);
        chk({tag, "_pulse"}, 32'({o_step_fwd, o_step_rev, o_err}), 32'(exp_pulse));
        chk({tag, "_pos"}, 32'(o_pos), 32'(exp_pos));
        chk({tag, "_dir"}, 32'(o_dir), 32'(exp_dir));
        cyc(1);
        chk({tag, "_post"}, 32'({o_step_fwd, o_step_rev, o_err}), 32'(3'b000));
        cyc(3);
    endtask

    initial begin
        i_rst     = 1'b0;
        i_phase   = 2'b11;
        i_pos_clr = 1'b0;
        cyc(3);
        chk("rst_outs", 32'({o_step_fwd, o_step_rev, o_err, o_dir, o_locked}), 32'(5'b0));
        chk("rst_pos", 32'(o_pos), 32'(0));
`ifdef STEP_SEQ_DEC_ERR_CNT_EN
        chk("rst_errcnt", 32'(o_err_cnt), 32'(0));
`endif

        // Release with 11 held: not locked yet at edge 2, locked by edge 6, no pulses.
        i_rst = 1'b1;
        cyc(2);
        chk("lock_early", 32'(o_locked), 32'(0));
        cyc(4);
        chk("lock_e6", 32'(o_locked), 32'(1));
        chk("lock_pulses", 32'({o_step_fwd, o_step_rev, o_err}), 32'(3'b000));
        chk("lock_pos", 32'(o_pos), 32'(0));
        cyc(4);

        // Full forward cycle 11->10->01->00->11.
        step_chk(2'b10, 3'b100, 8'd1, 1'b1, "fwd1");
        step_chk(2'b01, 3'b100, 8'd2, 1'b1, "fwd2");
        step_chk(2'b00, 3'b100, 8'd3, 1'b1, "fwd3");
        step_chk(2'b11, 3'b100, 8'd4, 1'b1, "fwd4");

        // Clear pos, then one reverse step wraps to 255.
        i_pos_clr = 1'b1;
        cyc(1);
        i_pos_clr = 1'b0;
        chk("clr_pos", 32'(o_pos), 32'(0));
        step_chk(2'b00, 3'b010, 8'd255, 1'b0, "rev_wrap");

        // Back to 11 then 10 (forward, wrapping 255 -> 0 -> 1).
        step_chk(2'b11, 3'b100, 8'd0, 1'b1, "fwd_wrap");
        step_chk(2'b10, 3'b100, 8'd1, 1'b1, "fwd_to10");

        // 3-cycle glitch to 01 then back to 10: nothing happens.
        i_phase = 2'b01;
        cyc(3);
        i_phase = 2'b10;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            chk($sformatf("glitch_c%0d", i), 32'({o_step_fwd, o_step_rev, o_err}), 32'(3'b000));
        end
        chk("glitch_pos", 32'(o_pos), 32'(1));
        chk("glitch_dir", 32'(o_dir), 32'(1));

        // Reverse to 11, then illegal jump 11 -> 01, then 00 is a forward step from 01.
        step_chk(2'b11, 3'b010, 8'd0, 1'b0, "rev_to11");
        step_chk(2'b01, 3'b001, 8'd0, 1'b0, "err_jump");
`ifdef STEP_SEQ_DEC_ERR_CNT_EN
        chk("errcnt_1", 32'(o_err_cnt), 32'(1));
`endif
        step_chk(2'b00, 3'b100, 8'd1, 1'b1, "after_err");

        // Walk forward up to pos=7 at cur=10.
        step_chk(2'b11, 3'b100, 8'd2, 1'b1, "walk2");
        step_chk(2'b10, 3'b100, 8'd3, 1'b1, "walk3");
        step_chk(2'b01, 3'b100, 8'd4, 1'b1, "walk4");
        step_chk(2'b00, 3'b100, 8'd5, 1'b1, "walk5");
        step_chk(2'b11, 3'b100, 8'd6, 1'b1, "walk6");
        step_chk(2'b10, 3'b100, 8'd7, 1'b1, "walk7");

        // pos_clr in the same cycle as the step: pulse still fires, pos cleared.
        i_phase = 2'b01;
        cyc(5);
        i_pos_clr = 1'b1;
        cyc(1);
        i_pos_clr = 1'b0;
        chk("clrstep_pulse", 32'({o_step_fwd, o_step_rev, o_err}), 32'(3'b100));
        chk("clrstep_pos", 32'(o_pos), 32'(0));
        chk("clrstep_dir", 32'(o_dir), 32'(1));
`ifdef STEP_SEQ_DEC_ERR_CNT_EN
        chk("clrstep_errcnt", 32'(o_err_cnt), 32'(0));
`endif
        cyc(2);

        // Asynchronous reset mid-sequence, away from any clock edge.
        i_phase = 2'b00;
        cyc(2);
        #2;
        i_rst = 1'b0;
        #1;
        chk("async_rst", 32'({o_step_fwd, o_step_rev, o_err, o_dir, o_locked}), 32'(5'b0));
        chk("async_rst_pos", 32'(o_pos), 32'(0));
        cyc(3);

        // Release with 00 held: relocks at edge 6 with no step.
        i_rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            chk($sformatf("relock_q%0d", i), 32'({o_step_fwd, o_step_rev, o_err}), 32'(3'b000));
            if (i == 5) chk("relock_e5", 32'(o_locked), 32'(0));
            if (i == 6) chk("relock_e6", 32'(o_locked), 32'(1));
        end
        chk("relock_pos", 32'(o_pos), 32'(0));
        chk("relock_dir", 32'(o_dir), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/step_seq_decoder.md
# step_seq_decoder

- Decodes a 2-bit phase sequence into direction and step events.
- Forward sequence: 11→10→01→00→11; reverse is the same order run backwards. This is the same stepping order the LED ring controller produces.
- Sits between raw 2-bit phase inputs (a rotary/stepping source or a looped-back LED ring) and the rest of the design.
- Produces debounced single-cycle step pulses, a wrapping position count, last direction, and an error pulse on illegal jumps.

## Interface
- STABLE_CYC, 1000: consecutive identical synchronized samples required to accept a phase value; legal range 2..2^20.
- POS_W, 8: width of the position counter.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- phase  in  2  raw asynchronous phase input.
- pos_clr  in  1  synchronous clear of pos; active high.
- step_fwd  out  1  one-cycle pulse on an accepted forward step.
- step_rev  out  1  one-cycle pulse on an accepted reverse step.
- err  out  1  one-cycle pulse on an accepted illegal transition (two-position jump).
- dir  out  1  last legal direction: 1 = forward, 0 = reverse.
- locked  out  1  high once a first phase value has been accepted after reset.
- pos  out  POS_W  signed-agnostic position count, modulo 2^POS_W.

## Operation
- **Synchronizer:** phase passes through a two-flop synchronizer to give s.
- **Stability filter:**
  - A candidate register and a counter are kept.
  - If s ≠ candidate: candidate ← s and cnt ← 0.
  - Otherwise cnt increments, saturating at STABLE_CYC-1.
  - A value is accepted in the cycle cnt reaches STABLE_CYC-1.
  - Acceptance fires once per stable run. It does not re-fire while the value is held.
- **Accepted-state register cur (states S0=11, S1=10, S2=01, S3=00):**
  - locked=0: the first accepted value loads cur and sets locked=1. No step, no err.
  - Accepted value = cur: no action.
  - Accepted value = forward successor of cur (S0→S1→S2→S3→S0): cur updates, step_fwd=1, pos+1, dir←1.
  - Accepted value = reverse successor of cur: cur updates, step_rev=1, pos-1, dir←0.
  - Accepted value = opposite state (S0↔S2, S1↔S3): cur updates, err=1, pos and dir unchanged.
- **Position arithmetic:** pos wraps modulo 2^POS_W in both directions (all-ones +1 → 0; 0 −1 → all-ones).
- **pos_clr:** sets pos to 0 on the next edge. If it coincides with a step, the clear wins (pos=0). The step pulse and dir update still occur.
- **Pulse exclusivity:** step_fwd, step_rev and err are mutually exclusive and registered.

## Timing
- Reset values: step_fwd=0, step_rev=0, err=0, dir=0, locked=0, pos=0, cur=11, cnt=0, synchronizer and candidate=11.
- Latency: a phase change set up before edge 0 and held gives s changed after edge 2. The resulting pulse is high after edge STABLE_CYC+2, for exactly one clock.
- Glitches:
  - Any run of s shorter than STABLE_CYC cycles is ignored entirely.
  - A value returning to cur after a glitch produces no output.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any pulse in flight is dropped. The first accepted value after release relocks with no step.
- Back-to-back steps: minimum spacing is STABLE_CYC cycles between pulses.

## Configuration
- Macro STEP_SEQ_DEC_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt, out, 8 bits, reset 0.
  - err_cnt increments on each err pulse and saturates at 255.
  - pos_clr also clears err_cnt.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use STABLE_CYC=4 and POS_W=8.
- Reset release with phase=11 held:
  - locked=1 at edge 6.
  - No pulse; pos=0.
- From locked at 11, apply 10, 01, 00, 11, each held 10 cycles:
  - Four step_fwd pulses, each at edge 6 after its change.
  - pos=4, dir=1.
- From pos=0 at 11, apply one reverse step (11→00):
  - step_rev pulses once.
  - pos=255, dir=0.
- At cur=10, glitch phase to 01 for 3 cycles, then return to 10:
  - No pulses; pos unchanged.
- From cur=11, jump to 01:
  - err pulses once; pos and dir unchanged; cur=01.
  - With STEP_SEQ_DEC_ERR_CNT_EN defined, err_cnt=1.
  - A following 00 produces step_fwd.
- Assert pos_clr in the cycle of a step_fwd while pos=7:
  - pos=0 and step_fwd is still pulsed.
  - Then pull rst low mid-sequence: all outputs are 0 immediately.
